// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher feeding an in-order
// instruction queue. A redirect flushes the queue and retargets the fetch PC.
// A request already on the bus when a redirect arrives is drained and its
// data is discarded.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [31:0]   stale_addr;
  logic [31:0]   redir_tgt;
  entry_t        q [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, count_nxt;
  logic          push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign redir_tgt = redirect_pc & ~32'h3;

  // A redirect overrides both queue ports in the cycle it arrives.
  assign push = (state == WAIT) && imem_ack && !redirect_valid;
  assign pop  = (count != '0) && instr_ready && !redirect_valid;

  // Queue occupancy after this cycle's push/pop/flush.
  always_comb begin
    count_nxt = count;
    if (redirect_valid)     count_nxt = '0;
    else if (push && !pop)  count_nxt = count + CW'(1);
    else if (pop && !push)  count_nxt = count - CW'(1);
  end

  // Next state and next fetch PC. The queue slot is reserved when the
  // request issues (count < DEPTH), so an acked word always fits.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    case (state)
      IDLE: begin
        if (redirect_valid)       fetch_pc_nxt = redir_tgt;
        else if (count < DEPTH_C) state_nxt    = WAIT;
      end
      WAIT: begin
        if (redirect_valid) begin
          fetch_pc_nxt = redir_tgt;
          state_nxt    = imem_ack ? IDLE : DRAIN;
        end else if (imem_ack) begin
          fetch_pc_nxt = fetch_pc + 32'd4;
          state_nxt    = (count_nxt < DEPTH_C) ? WAIT : IDLE;
        end
      end
      DRAIN: begin
        if (redirect_valid) fetch_pc_nxt = redir_tgt;
        // Leaving on ack even with a same-cycle redirect: the stale
        // request is finished and nothing else is outstanding.
        if (imem_ack)       state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state, fetch PC and the address of a request being drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      stale_addr <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      if (state == WAIT && redirect_valid && !imem_ack) stale_addr <= fetch_pc;
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      count <= count_nxt;
    end
  end

  // Queue storage; contents are only visible through a valid head.
  always_ff @(posedge clk) begin
    if (push) q[tail] <= '{pc: fetch_pc, word: imem_rdata};
  end

  assign imem_req    = (state == WAIT) || (state == DRAIN);
  assign imem_addr   = (state == DRAIN) ? stale_addr : fetch_pc;
  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? q[head].word : '0;
  assign instr_pc    = instr_valid ? q[head].pc   : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus against a queue-level model of the fetcher,
// checked every cycle, plus literal expectations for the key scenarios.
module tb_fetch_unit;
  localparam int DEPTH = 4;
  localparam logic [31:0] XORK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst, redirect_valid, instr_ready;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ack, instr_valid;
  logic [31:0] imem_addr, imem_rdata, instr, instr_pc;

  // second instance with a wrapping reset PC and its own zero-wait memory
  logic        w_req, w_ack, w_valid;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc));

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_w (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .instr_valid(w_valid), .instr_ready(1'b1),
    .instr(w_instr), .instr_pc(w_pc));

  assign w_ack   = w_req;
  assign w_rdata = w_addr ^ XORK;

  // memory responder: ack once the request has been held mem_lat cycles
  int mem_lat = 0;
  bit force_ack = 1'b0;
  int wait_cnt = 0;
  int ack_cnt = 0;
  assign imem_ack   = force_ack | (imem_req && (wait_cnt >= mem_lat));
  assign imem_rdata = imem_addr ^ XORK;

  always @(posedge clk) begin
    if (imem_ack || !imem_req) wait_cnt <= 0;
    else                       wait_cnt <= wait_cnt + 1;
    if (rst)                        ack_cnt <= 0;
    else if (imem_ack && imem_req)  ack_cnt <= ack_cnt + 1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: queue of {pc,word}, fetch PC, one outstanding request (maybe stale)
  logic [63:0] mq[$];
  logic [31:0] m_fpc = 32'h0, m_paddr = 32'h0;
  bit m_pend = 0, m_stale = 0, armed = 0;

  // compare against the model, then advance the model with the inputs that
  // the next rising edge will sample (inputs only change just after posedge)
  always @(negedge clk) begin
    if (armed) begin
      check("m_imem_req", imem_req, m_pend);
      if (m_pend) check("m_imem_addr", imem_addr, m_paddr);
      check("m_instr_valid", instr_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        check("m_instr_pc", instr_pc, mq[0][63:32]);
        check("m_instr", instr, mq[0][31:0]);
      end
    end
    if (rst) begin
      mq.delete();
      m_fpc = 32'h0; m_pend = 0; m_stale = 0; armed = 1;
    end else begin
      int  sz_pre;
      bit  acked;
      sz_pre = mq.size();
      acked  = m_pend && imem_ack;
      if (redirect_valid) begin
        mq.delete();
        m_fpc = redirect_pc & ~32'h3;
        if (acked) begin m_pend = 0; m_stale = 0; end
        else if (m_pend) m_stale = 1;
      end else begin
        if (mq.size() != 0 && instr_ready) void'(mq.pop_front());
        if (acked) begin
          m_pend = 0;
          if (m_stale) m_stale = 0;
          else begin
            mq.push_back({m_paddr, imem_rdata});
            m_fpc = m_fpc + 32'd4;
            if (mq.size() < DEPTH) begin m_pend = 1; m_paddr = m_fpc; end
          end
        end else if (!m_pend && sz_pre < DEPTH) begin
          m_pend = 1; m_paddr = m_fpc;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!instr_valid && n < 40) begin @(negedge clk); n++; end
    if (!instr_valid) check({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    logic [31:0] wexp;
    int n;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    tick();
    rst = 1'b0;

    // streaming with a zero-wait memory; the wrapping instance runs in step
    @(negedge clk);
    wait_valid("stream");
    wexp = 32'hFFFF_FFF8;
    for (int k = 0; k < 4; k++) begin
      check("stream_pc", instr_pc, 32'(k * 4));
      check("stream_instr", instr, 32'(k * 4) ^ XORK);
      check("stream_valid", instr_valid, 1'b1);
      check("wrap_pc", w_pc, wexp);
      wexp = wexp + 32'd4;
      @(negedge clk);
    end

    // back-pressure fills the queue, then drains in order
    instr_ready = 1'b0;
    do_reset();
    repeat (12) tick();
    @(negedge clk);
    check("full_imem_req", imem_req, 1'b0);
    check("full_instr_pc", instr_pc, 32'h0);
    tick();
    instr_ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("drain_pc", instr_pc, 32'(k * 4));
      @(negedge clk);
    end

    // redirect with 3 queued entries and a slow request outstanding
    instr_ready = 1'b0; mem_lat = 3;
    do_reset();
    n = 0;
    while (ack_cnt < 3 && n < 60) begin @(negedge clk); n++; end
    if (ack_cnt < 3) check("redir_setup_timeout", 32'd0, 32'd1);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_flush_valid", instr_valid, 1'b0);
    check("redir_drain_addr", imem_addr, 32'h0000_000C);
    wait_valid("redir");
    check("redir_pc", instr_pc, 32'h0000_0100);
    check("redir_instr", instr, 32'h0000_0100 ^ XORK);

    // redirect coincident with ack and pop
    mem_lat = 0; instr_ready = 1'b1;
    do_reset();
    repeat (4) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("coinc_valid", instr_valid, 1'b0);
    check("coinc_imem_req", imem_req, 1'b0);
    wait_valid("coinc");
    check("coinc_pc", instr_pc, 32'h0000_0200);

    // reset while draining; a late ack must be ignored
    mem_lat = 3; instr_ready = 1'b0;
    do_reset();
    n = 0;
    while (!imem_req && n < 10) begin @(negedge clk); n++; end
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0400;
    tick();
    redirect_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; force_ack = 1'b1;
    @(negedge clk);
    check("rdrain_valid", instr_valid, 1'b0);
    check("rdrain_req", imem_req, 1'b0);
    tick();
    force_ack = 1'b0;
    @(negedge clk);
    check("rdrain_valid2", instr_valid, 1'b0);
    check("rdrain_req2", imem_req, 1'b1);
    check("rdrain_addr", imem_addr, 32'h0000_0000);
    instr_ready = 1'b1;
    repeat (12) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
